// File: rtl/run_splitter_16.sv
// run_splitter_16: splits a stream of sorted runs into two show-ahead lane FIFOs, alternating lanes per run.
// Macro RUN_SPLITTER_TERM_EN adds an all-zero terminator beat after each run.
module run_splitter_16 #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [16*DATA_WIDTH-1:0] i_data,
  input  logic                     i_valid,
  input  logic                     i_last,
  output logic                     o_ready,
  output logic [16*DATA_WIDTH-1:0] o_fifo_1,
  output logic [16*DATA_WIDTH-1:0] o_fifo_2,
  output logic                     o_fifo_1_empty,
  output logic                     o_fifo_2_empty,
  input  logic                     i_fifo_1_read,
  input  logic                     i_fifo_2_read,
  output logic [15:0]              o_runs_done
);
  localparam int BW = 16 * DATA_WIDTH;
  localparam int AW = $clog2(DEPTH);
`ifdef RUN_SPLITTER_TERM_EN
  typedef enum logic [1:0] {FILL1, TERM1, FILL2, TERM2} state_t;
`else
  typedef enum logic {FILL1, FILL2} state_t;
`endif
  state_t state_q, state_d;
  logic [15:0] runs_q, runs_d;
  logic [1:0] push, pop, full, empty, rd;
  logic [1:0][BW-1:0] head;
  logic [BW-1:0] wdata;
  logic rdy;
  assign rd = {i_fifo_2_read, i_fifo_1_read};
  // Ready comes from registered occupancy and state only; held low while in reset.
  assign o_ready = rdy && i_rst_n;
  assign o_fifo_1 = head[0];
  assign o_fifo_2 = head[1];
  assign o_fifo_1_empty = empty[0];
  assign o_fifo_2_empty = empty[1];
  assign o_runs_done = runs_q;
  always_comb begin
    state_d = state_q;
    runs_d = runs_q;
    push = '0;
    wdata = i_data;
    rdy = 1'b0;
    case (state_q)
      FILL1: begin
        rdy = !full[0];
        push[0] = i_valid && rdy;
`ifdef RUN_SPLITTER_TERM_EN
        if (push[0] && i_last) state_d = TERM1;
`else
        if (push[0] && i_last) begin
          state_d = FILL2;
          runs_d = runs_q + 16'd1;
        end
`endif
      end
      FILL2: begin
        rdy = !full[1];
        push[1] = i_valid && rdy;
`ifdef RUN_SPLITTER_TERM_EN
        if (push[1] && i_last) state_d = TERM2;
`else
        if (push[1] && i_last) begin
          state_d = FILL1;
          runs_d = runs_q + 16'd1;
        end
`endif
      end
`ifdef RUN_SPLITTER_TERM_EN
      TERM1: begin
        wdata = '0;
        if (!full[0]) begin
          push[0] = 1'b1;
          runs_d = runs_q + 16'd1;
          state_d = FILL2;
        end
      end
      TERM2: begin
        wdata = '0;
        if (!full[1]) begin
          push[1] = 1'b1;
          runs_d = runs_q + 16'd1;
          state_d = FILL1;
        end
      end
`endif
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= FILL1;
      runs_q <= '0;
    end else begin
      state_q <= state_d;
      runs_q <= runs_d;
    end
  end
  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic [BW-1:0] mem_q [DEPTH];
    logic [AW:0] cnt_q;
    logic [AW-1:0] wp_q, rp_q;
    assign full[l] = cnt_q == (AW+1)'(DEPTH);
    assign empty[l] = cnt_q == '0;
    assign pop[l] = rd[l] && !empty[l];
    // Empty lanes present zero so the head reads clean after reset.
    assign head[l] = empty[l] ? '0 : mem_q[rp_q];
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        cnt_q <= '0;
        wp_q <= '0;
        rp_q <= '0;
      end else begin
        cnt_q <= cnt_q + (AW+1)'(push[l]) - (AW+1)'(pop[l]);
        if (push[l]) wp_q <= wp_q + 1'b1;
        if (pop[l]) rp_q <= rp_q + 1'b1;
      end
    end
    always_ff @(posedge i_clk) begin
      if (push[l]) mem_q[wp_q] <= wdata;
    end
  end
endmodule

// File: tb/tb_run_splitter_16.sv
// tb_run_splitter_16: random and directed stimulus against a queue-based lane model of run_splitter_16.
module tb_run_splitter_16;
  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int BW = 16 * DW;
  logic clk, rst_n, valid, last, read1, read2;
  logic [BW-1:0] data;
  logic o_ready, empty1, empty2;
  logic [BW-1:0] head1, head2;
  logic [15:0] runs;
  int n_cmp, n_fail;
  logic [BW-1:0] q1[$], q2[$];
  int cur;
  bit pend;
  logic [15:0] m_runs;
  run_splitter_16 #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .i_last(last),
    .o_ready(o_ready), .o_fifo_1(head1), .o_fifo_2(head2),
    .o_fifo_1_empty(empty1), .o_fifo_2_empty(empty2),
    .i_fifo_1_read(read1), .i_fifo_2_read(read2), .o_runs_done(runs)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask
  function automatic logic [BW-1:0] mk_beat(input int base);
    logic [BW-1:0] b;
    for (int i = 0; i < 16; i++) b[i*DW +: DW] = DW'(base + i);
    return b;
  endfunction
  function automatic logic [BW-1:0] rnd_beat();
    logic [BW-1:0] b;
    for (int i = 0; i < 16; i++) b[i*DW +: DW] = DW'($urandom);
    return b;
  endfunction
  // Model: each lane is a queue; runs go to lane (cur), terminator pending after a last beat when enabled.
  always @(negedge clk) begin
    int s1, s2, tsz;
    bit do_push, exp_rdy;
    logic [BW-1:0] pd;
    if (!rst_n) begin
      q1.delete();
      q2.delete();
      cur = 0;
      pend = 0;
      m_runs = '0;
    end
    s1 = q1.size();
    s2 = q2.size();
    tsz = (cur == 0) ? s1 : s2;
    exp_rdy = rst_n && !pend && tsz < DEPTH;
    chk("ready", BW'(o_ready), BW'(exp_rdy));
    chk("empty1", BW'(empty1), BW'(s1 == 0));
    chk("empty2", BW'(empty2), BW'(s2 == 0));
    chk("head1", head1, s1 > 0 ? q1[0] : '0);
    chk("head2", head2, s2 > 0 ? q2[0] : '0);
    chk("runs", BW'(runs), BW'(m_runs));
    if (rst_n) begin
      do_push = 0;
      pd = data;
      if (pend) begin
        if (tsz < DEPTH) begin
          do_push = 1;
          pd = '0;
        end
      end else if (valid && exp_rdy) do_push = 1;
      if (read1 && s1 > 0) void'(q1.pop_front());
      if (read2 && s2 > 0) void'(q2.pop_front());
      if (do_push) begin
        if (cur == 0) q1.push_back(pd);
        else q2.push_back(pd);
        if (pend) begin
          pend = 0;
          cur ^= 1;
          m_runs++;
        end else if (last) begin
`ifdef RUN_SPLITTER_TERM_EN
          pend = 1;
`else
          cur ^= 1;
          m_runs++;
`endif
        end
      end
    end
  end
  task automatic send(input logic [BW-1:0] d, input logic l);
    logic acc;
    int n;
    valid = 1;
    data = d;
    last = l;
    acc = 0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      n++;
    end
    valid = 0;
    last = 0;
    chk("send_accept", BW'(acc), BW'(1));
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask
  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 0;
    valid = 0;
    last = 0;
    read1 = 0;
    read2 = 0;
    data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("first_ready", BW'(o_ready), BW'(1));
    // Run of 3 beats, keys 1..48, lane 1 unread.
    @(posedge clk);
    #1;
    send(mk_beat(1), 0);
    send(mk_beat(17), 0);
    send(mk_beat(33), 1);
    @(negedge clk);
`ifdef RUN_SPLITTER_TERM_EN
    chk("ready_term", BW'(o_ready), BW'(0));
`else
    chk("ready_noterm", BW'(o_ready), BW'(1));
    chk("runs_after_run", BW'(runs), BW'(1));
`endif
    chk("lane1_head_lit", head1, mk_beat(1));
    @(posedge clk);
    #1;
`ifdef RUN_SPLITTER_TERM_EN
    chk("lane1_occ_lit", BW'(q1.size()), BW'(4));
`else
    chk("lane1_occ_lit", BW'(q1.size()), BW'(3));
`endif
    // Popping empty lane 2 must be harmless.
    read2 = 1;
    repeat (5) @(posedge clk);
    #1 read2 = 0;
    send(mk_beat(100), 0);
    @(negedge clk);
    chk("lane2_head_lit", head2, mk_beat(100));
    chk("lane1_kept_lit", head1, mk_beat(1));
    @(posedge clk);
    #1 read1 = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("drain1_lit", head1, mk_beat(1 + 16 * k));
      @(posedge clk);
      #1;
    end
`ifdef RUN_SPLITTER_TERM_EN
    @(negedge clk);
    chk("term_beat_lit", head1, '0);
    chk("term_present_lit", BW'(empty1), BW'(0));
    @(posedge clk);
    #1;
`endif
    read1 = 0;
    @(negedge clk);
    chk("drained_lit", BW'(empty1), BW'(1));
    chk("runs_one_lit", BW'(runs), BW'(1));
    // Async reset mid-run clears everything at once.
    do_reset();
    send(mk_beat(200), 0);
    send(mk_beat(216), 0);
    #3 rst_n = 0;
    #1;
    chk("rst_empty1", BW'(empty1), BW'(1));
    chk("rst_empty2", BW'(empty2), BW'(1));
    chk("rst_runs", BW'(runs), BW'(0));
    chk("rst_ready", BW'(o_ready), BW'(0));
    chk("rst_head1", head1, '0);
    @(posedge clk);
    #1 rst_n = 1;
    send(mk_beat(300), 1);
    @(negedge clk);
    chk("post_rst_lane1", head1, mk_beat(300));
    chk("post_rst_lane2", BW'(empty2), BW'(1));
    // Two runs of two beats each.
    do_reset();
    send(mk_beat(400), 0);
    send(mk_beat(416), 1);
    send(mk_beat(432), 0);
    send(mk_beat(448), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("two_runs_cnt", BW'(runs), BW'(2));
    chk("two_runs_h1", head1, mk_beat(400));
    chk("two_runs_h2", head2, mk_beat(432));
    // Fill lane 1 to DEPTH, then one pop lets exactly one beat in.
    do_reset();
    for (int k = 0; k < DEPTH; k++) send(mk_beat(500 + 16 * k), 0);
    valid = 1;
    data = mk_beat(900);
    @(negedge clk);
    chk("full_block", BW'(o_ready), BW'(0));
    @(posedge clk);
    #1 read1 = 1;
    @(posedge clk);
    #1 read1 = 0;
    @(negedge clk);
    chk("pop_frees", BW'(o_ready), BW'(1));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("refull", BW'(o_ready), BW'(0));
    @(posedge clk);
    #1 valid = 0;
    // Randomized traffic with varying read pressure.
    do_reset();
    for (int ph = 0; ph < 3; ph++) begin
      int p;
      p = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
      for (int c = 0; c < 1500; c++) begin
        @(posedge clk);
        #1;
        valid = ($urandom % 4) != 0;
        last = ($urandom % 5) == 0;
        data = rnd_beat();
        read1 = ($urandom % 100) < p;
        read2 = ($urandom % 100) < p;
      end
    end
    @(posedge clk);
    #1;
    valid = 0;
    read1 = 0;
    read2 = 0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
